// File: rtl/disp_pkg.sv
// Shared constants and the active-low seven-segment lookup for the display scanner.
//   NUM_DIGITS  : number of multiplexed digits on the board display
//   SEG_OFF     : segment pattern with every segment dark
//   seg7_lookup : hex nibble -> {g,f,e,d,c,b,a}, active-low
package disp_pkg;

   localparam int unsigned NUM_DIGITS = 8;
   localparam logic [6:0]  SEG_OFF    = 7'h7F;

   function automatic logic [6:0] seg7_lookup(input logic [3:0] i_hex);
      logic [6:0] w_seg;
      unique case (i_hex)
         4'h0: w_seg = 7'h40;
         4'h1: w_seg = 7'h79;
         4'h2: w_seg = 7'h24;
         4'h3: w_seg = 7'h30;
         4'h4: w_seg = 7'h19;
         4'h5: w_seg = 7'h12;
         4'h6: w_seg = 7'h02;
         4'h7: w_seg = 7'h78;
         4'h8: w_seg = 7'h00;
         4'h9: w_seg = 7'h10;
         4'hA: w_seg = 7'h08;
         4'hB: w_seg = 7'h03;
         4'hC: w_seg = 7'h46;
         4'hD: w_seg = 7'h21;
         4'hE: w_seg = 7'h06;
         4'hF: w_seg = 7'h0E;
         default: w_seg = SEG_OFF;
      endcase
      return w_seg;
   endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Bundle of the scanner's data/control inputs and display-drive outputs.
//   disp_data  : 8 packed hex nibbles, digit d in bits [4d+3:4d]
//   digit_en   : per-digit enable (0 keeps the digit dark)
//   dp_mask    : per-digit decimal point request (1 lights it)
//   lz_en      : leading-zero blanking enable
//   freeze     : hold the current snapshot across the next frame start
//   an         : anodes, active-low
//   seg        : {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame_tick : one-cycle pulse at each frame start
// master = register-file side driving the data, slave = the scanner.
interface hex_display_scanner_if;
   import disp_pkg::*;

   logic [31:0]           disp_data;
   logic [NUM_DIGITS-1:0] digit_en;
   logic [NUM_DIGITS-1:0] dp_mask;
   logic                  lz_en;
   logic                  freeze;
   logic [NUM_DIGITS-1:0] an;
   logic [6:0]            seg;
   logic                  dp;
   logic                  frame_tick;

   modport master (
      output disp_data, digit_en, dp_mask, lz_en, freeze,
      input  an, seg, dp, frame_tick
   );

   modport slave (
      input  disp_data, digit_en, dp_mask, lz_en, freeze,
      output an, seg, dp, frame_tick
   );

endinterface

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-seven-segment decoder (active-low segments).
//   i_hex : 4-bit hex value
//   o_seg : {g,f,e,d,c,b,a}, 0 = segment lit
module hex_to_seg7
   import disp_pkg::*;
(
   input  logic [3:0] i_hex,
   output logic [6:0] o_seg
);

   assign o_seg = seg7_lookup(i_hex);

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexed driver for an 8-digit common-anode seven-segment display.
// Snapshots disp_data once per frame, then scans digits 0..7 with a blanked
// guard at the start of every dwell, optional leading-zero blanking and
// decimal-point control. All outputs are registered.
//   clock : system clock, posedge
//   reset : synchronous, active-high
//   bus   : slave side of hex_display_scanner_if (data/control in, drive out)
module hex_display_scanner
   import disp_pkg::*;
#(
   parameter int unsigned DIGIT_CYCLES = 100000,
   parameter int unsigned BLANK_CYCLES = 1000
) (
   input  logic                  clock,
   input  logic                  reset,
   hex_display_scanner_if.slave  bus
);

   localparam int unsigned    CNT_W     = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
   localparam int unsigned    IDX_W     = $clog2(NUM_DIGITS);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(BLANK_CYCLES);

   logic [CNT_W-1:0]      r_cnt;
   logic [IDX_W-1:0]      r_idx;
   logic [31:0]           r_shadow;
   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_seg;
   logic                  r_dp;
   logic                  r_frame_tick;

   logic                  w_frame_start;
   logic                  w_dwell_end;
   logic [3:0]            w_nibble;
   logic [6:0]            w_seg_code;
   logic [NUM_DIGITS-1:0] w_zero_from;
   logic                  w_lz_blank;
   logic [NUM_DIGITS-1:0] w_an;
   logic [6:0]            w_seg;
   logic                  w_dp;

   assign w_frame_start = (r_cnt == '0) && (r_idx == '0);
   assign w_dwell_end   = (r_cnt == CNT_LAST);

   // Dwell counter and digit index; idx wraps 7 -> 0 by overflow since
   // NUM_DIGITS is a power of two.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt <= '0;
         r_idx <= '0;
      end else if (w_dwell_end) begin
         r_cnt <= '0;
         r_idx <= r_idx + 1'b1;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // One snapshot per frame keeps a frame from mixing old and new digits.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_shadow <= '0;
      end else if (w_frame_start && !bus.freeze) begin
         r_shadow <= bus.disp_data;
      end
   end

   // w_zero_from[d]: every nibble from d up to the top one is zero.
   for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_zero_from
      assign w_zero_from[d] = ~|r_shadow[31:4*d];
   end

   assign w_nibble   = r_shadow[{r_idx, 2'b00} +: 4];
   assign w_lz_blank = bus.lz_en && (r_idx != '0) && w_zero_from[r_idx];

   hex_to_seg7 u_hex_to_seg7 (
      .i_hex (w_nibble),
      .o_seg (w_seg_code)
   );

   // Guard and disabled digits fully dark; leading-zero blank keeps the
   // anode and decimal point but suppresses the segments.
   always_comb begin
      w_an  = '1;
      w_seg = SEG_OFF;
      w_dp  = 1'b1;
      if ((r_cnt >= CNT_GUARD) && bus.digit_en[r_idx]) begin
         w_an[r_idx] = 1'b0;
         w_dp        = ~bus.dp_mask[r_idx];
         if (!w_lz_blank) begin
            w_seg = w_seg_code;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_an         <= '1;
         r_seg        <= SEG_OFF;
         r_dp         <= 1'b1;
         r_frame_tick <= 1'b0;
      end else begin
         r_an         <= w_an;
         r_seg        <= w_seg;
         r_dp         <= w_dp;
         r_frame_tick <= w_frame_start;
      end
   end

   assign bus.an         = r_an;
   assign bus.seg        = r_seg;
   assign bus.dp         = r_dp;
   assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner with DIGIT_CYCLES=8, BLANK_CYCLES=2.
// The reference model derives every output from the cycle number since reset
// (frame phase, digit slot, dwell position) and a per-frame snapshot.
module tb_hex_display_scanner;

   localparam int DC    = 8;
   localparam int BC    = 2;
   localparam int FRAME = 8 * DC;

   logic clock = 1'b0;
   logic reset;

   hex_display_scanner_if bus ();

   hex_display_scanner #(
      .DIGIT_CYCLES (DC),
      .BLANK_CYCLES (BC)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   int          checks = 0;
   int          errors = 0;
   int          t      = 0;
   logic [31:0] m_shadow = 32'h0;
   logic [7:0]  e_an;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic        e_tick;

   // Predicts the outputs of the next cycle from the present cycle's inputs,
   // then advances one clock; t is the index of the cycle now visible.
   task automatic step();
      int         p;
      int         c;
      logic [2:0] d3;
      logic [3:0] nib;
      logic       was_rst;
      was_rst = reset;
      e_an    = 8'hFF;
      e_seg   = 7'h7F;
      e_dp    = 1'b1;
      e_tick  = 1'b0;
      if (reset) begin
         m_shadow = 32'h0;
      end else begin
         p      = t % FRAME;
         d3     = 3'(p / DC);
         c      = p % DC;
         e_tick = (p == 0);
         if (c >= BC && bus.digit_en[d3]) begin
            nib  = 4'(m_shadow >> (4 * d3));
            e_an = ~(8'd1 << d3);
            e_dp = ~bus.dp_mask[d3];
            if (bus.lz_en && d3 != 3'd0 && (m_shadow >> (4 * d3)) == 32'd0) e_seg = 7'h7F;
            else e_seg = seg_tab[nib];
         end
         if (p == 0 && !bus.freeze) m_shadow = bus.disp_data;
      end
      @(posedge clock);
      #1;
      t = was_rst ? 0 : t + 1;
   endtask

   task automatic do_reset(input int n);
      reset = 1'b1;
      for (int i = 0; i < n; i++) step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      bus.disp_data = $urandom;
      reset = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL reset i=%0d got an=%h seg=%h dp=%b tick=%b required an=ff seg=7f dp=1 tick=0",
                     i, bus.an, bus.seg, bus.dp, bus.frame_tick);
         end
         checks++;
      end
      reset = 1'b0;
   endtask

   task automatic test_scan_order();
      bus.disp_data = 32'h76543210;
      bus.digit_en  = 8'hFF;
      bus.dp_mask   = 8'h00;
      bus.lz_en     = 1'b0;
      bus.freeze    = 1'b0;
      do_reset(2);
      while (t < 70) begin
         step();
         if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
            errors++;
            $display("FAIL scan t=%0d got an=%h seg=%h dp=%b tick=%b required an=%h seg=%h dp=%b tick=%b",
                     t, bus.an, bus.seg, bus.dp, bus.frame_tick, e_an, e_seg, e_dp, e_tick);
         end
         checks++;
         if ((t >= 3 && t <= 8 && {bus.an, bus.seg} !== {8'hFE, 7'h40}) ||
             (t >= 11 && t <= 16 && {bus.an, bus.seg} !== {8'hFD, 7'h79}) ||
             ((t == 9 || t == 10) && bus.an !== 8'hFF) ||
             (bus.frame_tick !== (t == 1 || t == 65))) begin
            errors++;
            $display("FAIL scan_directed t=%0d got an=%h seg=%h tick=%b", t, bus.an, bus.seg,
                     bus.frame_tick);
         end
         checks++;
      end
   endtask

   task automatic test_snapshot(input logic use_freeze);
      bus.disp_data = 32'h0;
      bus.digit_en  = 8'hFF;
      bus.lz_en     = 1'b0;
      bus.freeze    = 1'b0;
      do_reset(1);
      while (t < 80) begin
         if (t == 20) bus.disp_data = 32'h00000008;
         bus.freeze = use_freeze && (t == 64);
         step();
         if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
            errors++;
            $display("FAIL snapshot frz=%b t=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     use_freeze, t, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
         end
         checks++;
         if ((t == 8 || t == 67) && bus.seg !== ((t == 67 && !use_freeze) ? 7'h00 : 7'h40)) begin
            errors++;
            $display("FAIL snapshot_digit0 frz=%b t=%0d got seg=%h", use_freeze, t, bus.seg);
         end
         if (t == 8 || t == 67) checks++;
      end
      bus.freeze = 1'b0;
   endtask

   task automatic test_leading_zero();
      bus.disp_data = 32'h00000A05;
      bus.lz_en     = 1'b1;
      bus.dp_mask   = 8'h08;
      bus.digit_en  = 8'hFF;
      do_reset(1);
      while (t < 2 * FRAME) begin
         step();
         if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
            errors++;
            $display("FAIL lz t=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     t, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
         end
         checks++;
         if (t == 27 && {bus.an, bus.seg, bus.dp} !== {8'hF7, 7'h7F, 1'b0}) begin
            errors++;
            $display("FAIL lz_digit3 got an=%h seg=%h dp=%b required an=f7 seg=7f dp=0",
                     bus.an, bus.seg, bus.dp);
         end
         if (t == 27) checks++;
         if (t == 19 && {bus.an, bus.seg} !== {8'hFB, 7'h08}) begin
            errors++;
            $display("FAIL lz_digit2 got an=%h seg=%h required an=fb seg=08", bus.an, bus.seg);
         end
         if (t == 19) checks++;
      end
      bus.lz_en   = 1'b0;
      bus.dp_mask = 8'h00;
   endtask

   task automatic test_digit_en();
      bus.disp_data = $urandom;
      bus.digit_en  = 8'hF0;
      do_reset(1);
      while (t < FRAME + 2) begin
         step();
         if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
            errors++;
            $display("FAIL digit_en t=%0d got an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                     t, bus.an, bus.seg, bus.dp, e_an, e_seg, e_dp);
         end
         checks++;
         if (t >= 1 && t <= 4 * DC && bus.an !== 8'hFF) begin
            errors++;
            $display("FAIL digit_en_dark t=%0d got an=%h required an=ff", t, bus.an);
         end
         if (t >= 1 && t <= 4 * DC) checks++;
      end
      bus.digit_en = 8'hFF;
   endtask

   task automatic test_reset_mid_frame();
      bus.disp_data = $urandom;
      do_reset(1);
      while (t < 30) step();
      bus.disp_data = $urandom;
      do_reset(2);
      if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL mid_reset_t0 got an=%h seg=%h dp=%b tick=%b", bus.an, bus.seg, bus.dp,
                  bus.frame_tick);
      end
      checks++;
      while (t < 20) begin
         step();
         if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
            errors++;
            $display("FAIL mid_reset t=%0d got an=%h seg=%h tick=%b required an=%h seg=%h tick=%b",
                     t, bus.an, bus.seg, bus.frame_tick, e_an, e_seg, e_tick);
         end
         checks++;
         if (t == 3 && {bus.an, bus.seg} !== {8'hFE, seg_tab[bus.disp_data[3:0]]}) begin
            errors++;
            $display("FAIL mid_reset_digit0 got an=%h seg=%h", bus.an, bus.seg);
         end
         if (t == 3) checks++;
      end
   endtask

   task automatic test_decode_sweep();
      logic [31:0] word;
      for (int v = 0; v < 16; v++) begin
         while ((t % FRAME) != 1) step();
         word          = $urandom;
         word[3:0]     = 4'(v);
         bus.disp_data = word;
         for (int i = 0; i < FRAME + 2; i++) begin
            step();
            if ({bus.an, bus.seg, bus.dp} !== {e_an, e_seg, e_dp}) begin
               errors++;
               $display("FAIL sweep v=%0d t=%0d got an=%h seg=%h required an=%h seg=%h",
                        v, t, bus.an, bus.seg, e_an, e_seg);
            end
            checks++;
         end
         if ({bus.an, bus.seg} !== {8'hFE, seg_tab[v]}) begin
            errors++;
            $display("FAIL sweep_code v=%0d got an=%h seg=%h required an=fe seg=%h",
                     v, bus.an, bus.seg, seg_tab[v]);
         end
         checks++;
      end
   endtask

   task automatic test_random();
      do_reset(1);
      for (int i = 0; i < 8 * FRAME; i++) begin
         bus.disp_data = ($urandom_range(0, 1) != 0) ? $urandom : ($urandom >> $urandom_range(0, 31));
         bus.digit_en  = 8'($urandom);
         bus.dp_mask   = 8'($urandom);
         bus.lz_en     = 1'($urandom);
         bus.freeze    = ($urandom_range(0, 3) == 0);
         step();
         if ({bus.an, bus.seg, bus.dp, bus.frame_tick} !== {e_an, e_seg, e_dp, e_tick}) begin
            errors++;
            $display("FAIL random t=%0d got an=%h seg=%h dp=%b tick=%b required an=%h seg=%h dp=%b tick=%b",
                     t, bus.an, bus.seg, bus.dp, bus.frame_tick, e_an, e_seg, e_dp, e_tick);
         end
         checks++;
      end
      bus.freeze = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      bus.disp_data = 32'h0;
      bus.digit_en  = 8'hFF;
      bus.dp_mask   = 8'h00;
      bus.lz_en     = 1'b0;
      bus.freeze    = 1'b0;
      test_reset();
      test_scan_order();
      test_snapshot(1'b0);
      test_snapshot(1'b1);
      test_leading_zero();
      test_digit_en();
      test_reset_mid_frame();
      test_decode_sweep();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
